// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//   Hazard / forwarding controller for the pipelined miniRV core.
//   A small scoreboard tracks the destination of every instruction in flight
//   after ID (entry 0 = EX ... entry FWD_STAGES-1 = WB). For each ID source
//   register the youngest matching entry is chosen: if its value is already
//   available it is forwarded, otherwise a load-use stall is raised.
//   Redirects produce a FLUSH_CYCLES-long flush window. A data memory that is
//   not ready freezes the whole pipeline, including this scoreboard.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid_i            ID holds a real instruction
//   id_rs1_i / id_rs2_i   ID source register indices
//   id_rd_i, id_we_i      ID destination index and its write enable
//   id_is_load_i          ID instruction is a load
//   stage_data_i          result of entry k at [k*XLEN +: XLEN]
//   redirect_i            EX resolved a taken branch/jump (used when mem ready)
//   mem_ready_i           data memory finished this cycle
//   stall_if_o            hold PC
//   stall_id_o            hold IF/ID, insert bubble into EX
//   flush_if_id_o         kill IF/ID contents
//   freeze_o              hold every pipeline register
//   fwd_a_hit_o / fwd_b_hit_o    use forwarded value for rs1 / rs2
//   fwd_a_data_o / fwd_b_data_o  forwarded rs1 / rs2 value
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int FWD_STAGES   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid_i,
  input  logic [REG_AW-1:0]          id_rs1_i,
  input  logic [REG_AW-1:0]          id_rs2_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic                       id_we_i,
  input  logic                       id_is_load_i,
  input  logic [FWD_STAGES*XLEN-1:0] stage_data_i,
  input  logic                       redirect_i,
  input  logic                       mem_ready_i,
  output logic                       stall_if_o,
  output logic                       stall_id_o,
  output logic                       flush_if_id_o,
  output logic                       freeze_o,
  output logic                       fwd_a_hit_o,
  output logic                       fwd_b_hit_o,
  output logic [XLEN-1:0]            fwd_a_data_o,
  output logic [XLEN-1:0]            fwd_b_data_o
);

  // Counter holds at most FLUSH_CYCLES-1.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Scoreboard: write-enable and rd!=0 are folded into vld.
  logic [FWD_STAGES-1:0]             vld_q, vld_d;
  logic [FWD_STAGES-1:0]             ld_q, ld_d;
  logic [FWD_STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic [FWD_STAGES-1:0] ready_s;
  logic [XLEN+1:0]       look_a_s, look_b_s;
  logic                  haz_s;
  logic                  flush_active_s;
  logic                  stall_s;

  // Youngest-match lookup: returns {hit, hazard, data}. A younger match that
  // is not yet ready blocks any older ready match.
  function automatic logic [XLEN+1:0] fwd_lookup(
    input logic [REG_AW-1:0]                  rs,
    input logic [FWD_STAGES-1:0]              vld,
    input logic [FWD_STAGES-1:0][REG_AW-1:0]  rd,
    input logic [FWD_STAGES-1:0]              rdy,
    input logic [FWD_STAGES*XLEN-1:0]         data
  );
    logic            seen;
    logic            hit;
    logic            haz;
    logic [XLEN-1:0] val;
    seen = 1'b0;
    hit  = 1'b0;
    haz  = 1'b0;
    val  = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!seen && vld[k] && (rd[k] == rs) && (rs != '0)) begin
        seen = 1'b1;
        if (rdy[k]) begin
          hit = 1'b1;
          val = data[k*XLEN +: XLEN];
        end else begin
          haz = 1'b1;
        end
      end else begin
        seen = seen;
      end
    end
    return {hit, haz, val};
  endfunction

  // Per-entry readiness: load data only exists from entry LOAD_LAT onward.
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (k >= LOAD_LAT) begin
        ready_s[k] = 1'b1;
      end else begin
        ready_s[k] = ~ld_q[k];
      end
    end
  end

  // Forwarding selection and hazard/stall/flush decode.
  always_comb begin
    look_a_s       = fwd_lookup(id_rs1_i, vld_q, rd_q, ready_s, stage_data_i);
    look_b_s       = fwd_lookup(id_rs2_i, vld_q, rd_q, ready_s, stage_data_i);
    haz_s          = look_a_s[XLEN] | look_b_s[XLEN];
    flush_active_s = redirect_i | (cnt_q != '0);
    stall_s        = id_valid_i & haz_s & ~flush_active_s & mem_ready_i;
  end

  assign freeze_o      = ~mem_ready_i;
  assign flush_if_id_o = flush_active_s & mem_ready_i;
  assign stall_if_o    = stall_s;
  assign stall_id_o    = stall_s;
  assign fwd_a_hit_o   = look_a_s[XLEN+1];
  assign fwd_b_hit_o   = look_b_s[XLEN+1];
  assign fwd_a_data_o  = look_a_s[XLEN-1:0];
  assign fwd_b_data_o  = look_b_s[XLEN-1:0];

  // Next-state: shift scoreboard and step flush counter unless frozen.
  always_comb begin
    vld_d = vld_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (mem_ready_i) begin
      for (int k = 1; k < FWD_STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      // A stalled or flushed ID sends a bubble into EX.
      if (stall_s || flush_active_s) begin
        vld_d[0] = 1'b0;
        ld_d[0]  = 1'b0;
        rd_d[0]  = '0;
      end else begin
        vld_d[0] = id_valid_i & id_we_i & (id_rd_i != '0);
        ld_d[0]  = id_is_load_i;
        rd_d[0]  = id_rd_i;
      end
      // A redirect inside an open window restarts it.
      if (redirect_i) begin
        cnt_d = CNT_RELOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NS   = 4;
  localparam int LAT  = 2;
  localparam int FC   = 2;

  logic            clk;
  logic            rst_n;
  logic            id_valid, id_we, id_is_load, redirect, mem_ready;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic [NS*XLEN-1:0] stage_data;
  logic            stall_if, stall_id, flush_if_id, freeze, hit_a, hit_b;
  logic [XLEN-1:0] data_a, data_b;

  int n_chk;
  int n_pass;

  // Reference model: list of in-flight writers indexed by age (cycles since ID).
  bit          m_vld [NS];
  logic [AW-1:0] m_rd [NS];
  bit          m_ld  [NS];
  int          m_cnt;
  bit          e_stall, e_flush, e_freeze, e_hit_a, e_hit_b, e_act;
  logic [XLEN-1:0] e_da, e_db;
  bit          e_haz_a, e_haz_b;

  pipe_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .FWD_STAGES(NS), .LOAD_LAT(LAT),
                     .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_we_i(id_we), .id_is_load_i(id_is_load), .stage_data_i(stage_data),
    .redirect_i(redirect), .mem_ready_i(mem_ready),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .flush_if_id_o(flush_if_id),
    .freeze_o(freeze), .fwd_a_hit_o(hit_a), .fwd_b_hit_o(hit_b),
    .fwd_a_data_o(data_a), .fwd_b_data_o(data_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] sd(input int k);
    return stage_data[k*XLEN +: XLEN];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NS; k++) begin
      m_vld[k] = 1'b0; m_rd[k] = '0; m_ld[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Source lookup in the model: the youngest writer of rs decides. A load
  // still needs (LAT - age) cycles before its value exists.
  task automatic model_src(input logic [AW-1:0] rs, output bit hit, output bit haz,
                           output logic [XLEN-1:0] d);
    bit found;
    found = 1'b0; hit = 1'b0; haz = 1'b0; d = '0;
    if (rs != 0) begin
      for (int age = 0; age < NS; age++) begin
        if (!found && m_vld[age] && m_rd[age] == rs) begin
          found = 1'b1;
          if (m_ld[age] && (LAT - age) > 0) haz = 1'b1;
          else begin hit = 1'b1; d = sd(age); end
        end
      end
    end
  endtask

  task automatic model_eval();
    e_freeze = !mem_ready;
    model_src(id_rs1, e_hit_a, e_haz_a, e_da);
    model_src(id_rs2, e_hit_b, e_haz_b, e_db);
    e_act   = redirect || (m_cnt > 0);
    e_flush = e_act && !e_freeze;
    e_stall = id_valid && (e_haz_a || e_haz_b) && !e_act && !e_freeze;
  endtask

  task automatic model_clock();
    model_eval();
    if (mem_ready) begin
      for (int age = NS - 1; age > 0; age--) begin
        m_vld[age] = m_vld[age-1]; m_rd[age] = m_rd[age-1]; m_ld[age] = m_ld[age-1];
      end
      if (e_stall || e_act) begin
        m_vld[0] = 1'b0; m_rd[0] = '0; m_ld[0] = 1'b0;
      end else begin
        m_vld[0] = id_valid && id_we && (id_rd != 0); m_rd[0] = id_rd; m_ld[0] = id_is_load;
      end
      if (redirect) m_cnt = FC - 1;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit we, input bit ld);
    id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
    id_we = we; id_is_load = ld;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; mem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NS; k++) stage_data[k*XLEN +: XLEN] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; redirect = 1'b0;
    rand_data();
    set_id(1, 3, 4, 3, 1, 0);
    #2;
    n_chk++; if ({stall_if, stall_id, flush_if_id, freeze, hit_a, hit_b} !== 6'b0)
      $display("FAIL rst_flags got %b exp 000000", {stall_if, stall_id, flush_if_id, freeze, hit_a, hit_b});
    else n_pass++;
    n_chk++; if ({data_a, data_b} !== 64'h0) $display("FAIL rst_data got %h exp 0", {data_a, data_b});
    else n_pass++;
    mem_ready = 1'b0; #1;
    n_chk++; if (freeze !== 1'b1) $display("FAIL rst_freeze got %b exp 1", freeze); else n_pass++;
    do_reset();
  endtask

  task automatic test_alu_fwd();
    do_reset(); rand_data();
    set_id(1, 0, 0, 5, 1, 0); tick();
    set_id(1, 5, 0, 9, 1, 0); settle();
    n_chk++; if (hit_a !== 1'b1 || data_a !== sd(0))
      $display("FAIL alu_fwd got hit=%b data=%h exp hit=1 data=%h", hit_a, data_a, sd(0));
    else n_pass++;
    n_chk++; if (stall_if !== 1'b0) $display("FAIL alu_nostall got %b exp 0", stall_if); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    int  stalls;
    bit  got;
    // Load directly ahead: LAT-0 = 2 stall cycles, then forward from entry 2.
    do_reset(); rand_data();
    set_id(1, 0, 0, 7, 1, 1); tick();
    set_id(1, 7, 0, 9, 1, 0);
    stalls = 0; got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      settle();
      if (hit_a) begin
        got = 1'b1;
        n_chk++; if (data_a !== sd(2) || stall_id !== 1'b0)
          $display("FAIL lu_fwd got data=%h stall=%b exp data=%h stall=0", data_a, stall_id, sd(2));
        else n_pass++;
      end else if (stall_if && stall_id) stalls++;
      tick();
    end
    n_chk++; if (!got) $display("FAIL lu_timeout got nohit exp hit"); else n_pass++;
    n_chk++; if (stalls != 2) $display("FAIL lu_stalls got %0d exp 2", stalls); else n_pass++;
    // Load one instruction ahead: LAT-1 = 1 stall cycle.
    set_id(1, 0, 0, 7, 1, 1); tick();
    set_id(1, 0, 0, 11, 1, 0); tick();
    set_id(1, 0, 7, 12, 1, 0); settle();
    n_chk++; if (stall_id !== 1'b1) $display("FAIL lu1_stall got %b exp 1", stall_id); else n_pass++;
    tick(); settle();
    n_chk++; if (stall_id !== 1'b0 || hit_b !== 1'b1 || data_b !== sd(2))
      $display("FAIL lu1_fwd got stall=%b hit=%b data=%h exp 0 1 %h", stall_id, hit_b, data_b, sd(2));
    else n_pass++;
    tick();
  endtask

  task automatic test_youngest();
    do_reset(); rand_data();
    set_id(1, 0, 0, 8, 1, 0); tick();
    set_id(1, 0, 0, 0, 1, 0); tick();
    set_id(1, 0, 0, 8, 1, 0); tick();
    set_id(1, 8, 0, 9, 1, 0); settle();
    n_chk++; if (hit_a !== 1'b1 || data_a !== sd(0))
      $display("FAIL young_fwd got hit=%b data=%h exp 1 %h", hit_a, data_a, sd(0));
    else n_pass++;
    n_chk++; if (hit_b !== 1'b0 || data_b !== 32'h0)
      $display("FAIL x0_nohit got hit=%b data=%h exp 0 0", hit_b, data_b);
    else n_pass++;
    set_id(1, 8, 0, 8, 1, 1); tick();
    set_id(1, 0, 8, 9, 1, 0); settle();
    n_chk++; if (hit_b !== 1'b0 || stall_if !== 1'b1)
      $display("FAIL young_load_blocks got hit=%b stall=%b exp 0 1", hit_b, stall_if);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    do_reset(); rand_data();
    set_id(1, 0, 0, 7, 1, 1); tick();
    set_id(1, 7, 0, 10, 1, 0); redirect = 1'b1; settle();
    n_chk++; if (flush_if_id !== 1'b1 || stall_if !== 1'b0)
      $display("FAIL flush_c1 got flush=%b stall=%b exp 1 0", flush_if_id, stall_if);
    else n_pass++;
    tick(); redirect = 1'b0; settle();
    n_chk++; if (flush_if_id !== 1'b1 || stall_id !== 1'b0)
      $display("FAIL flush_c2 got flush=%b stall=%b exp 1 0", flush_if_id, stall_id);
    else n_pass++;
    tick();
    set_id(1, 7, 10, 11, 1, 0); settle();
    n_chk++; if (flush_if_id !== 1'b0) $display("FAIL flush_end got %b exp 0", flush_if_id); else n_pass++;
    n_chk++; if (hit_a !== 1'b1 || data_a !== sd(2) || hit_b !== 1'b0 || stall_if !== 1'b0)
      $display("FAIL flush_bubbles got a=%b %h b=%b st=%b exp 1 %h 0 0", hit_a, data_a, hit_b, stall_if, sd(2));
    else n_pass++;
    tick();
  endtask

  task automatic test_freeze();
    int stalls;
    do_reset(); rand_data();
    set_id(1, 0, 0, 7, 1, 1); tick();
    set_id(1, 7, 0, 9, 1, 0); settle();
    stalls = stall_id ? 1 : 0;
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_chk++; if (freeze !== 1'b1 || stall_if !== 1'b0 || flush_if_id !== 1'b0 || hit_a !== 1'b0)
        $display("FAIL frz_c%0d got fr=%b st=%b fl=%b hit=%b exp 1 0 0 0", c, freeze, stall_if, flush_if_id, hit_a);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1; settle();
    if (stall_id) stalls++;
    tick(); settle();
    n_chk++; if (stalls != 2 || hit_a !== 1'b1 || data_a !== sd(2))
      $display("FAIL frz_resume got stalls=%0d hit=%b data=%h exp 2 1 %h", stalls, hit_a, data_a, sd(2));
    else n_pass++;
    tick();
    set_id(1, 0, 0, 7, 1, 1); tick();
    set_id(1, 7, 0, 9, 1, 0); settle();
    rst_n = 1'b0; model_clear(); #1;
    n_chk++; if ({stall_if, stall_id, flush_if_id, freeze, hit_a, hit_b} !== 6'b0)
      $display("FAIL rst_mid got %b exp 000000", {stall_if, stall_id, flush_if_id, freeze, hit_a, hit_b});
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; settle();
    n_chk++; if (hit_a !== 1'b0 || stall_if !== 1'b0)
      $display("FAIL rst_stale got hit=%b stall=%b exp 0 0", hit_a, stall_if);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      redirect  = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      settle();
      n_chk++; if ({stall_if, stall_id, flush_if_id, freeze} !== {e_stall, e_stall, e_flush, e_freeze})
        $display("FAIL rnd_ctrl c=%0d got %b exp %b", c, {stall_if, stall_id, flush_if_id, freeze},
                 {e_stall, e_stall, e_flush, e_freeze});
      else n_pass++;
      n_chk++; if (hit_a !== e_hit_a || data_a !== e_da)
        $display("FAIL rnd_a c=%0d got %b %h exp %b %h", c, hit_a, data_a, e_hit_a, e_da);
      else n_pass++;
      n_chk++; if (hit_b !== e_hit_b || data_b !== e_db)
        $display("FAIL rnd_b c=%0d got %b %h exp %b %h", c, hit_b, data_b, e_hit_b, e_db);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    stage_data = '0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_flush();
    test_freeze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
